// File: rtl/m_bp_btb.sv
// rtl/m_bp_btb.sv - direct-mapped BTB with 2-bit saturating counters
// Prediction is combinational from registered state; a walking clear invalidates the table after reset.
module m_bp_btb #(
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic [31:0] w_pc,
  output logic        w_bp_tkn,
  output logic [31:0] w_ppc,
  output logic        w_ready,
  input  logic        w_upd,
  input  logic [31:0] w_upd_pc,
  input  logic        w_upd_tkn,
  input  logic [31:0] w_upd_tpc
);

  localparam int TAGW = 30 - IDXW;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   clr_idx_q, clr_idx_d;
  logic              valid_q [ENTRIES];
  logic              valid_d [ENTRIES];
  logic [TAGW-1:0]   tag_q   [ENTRIES];
  logic [TAGW-1:0]   tag_d   [ENTRIES];
  logic [29:0]       tgt_q   [ENTRIES];
  logic [29:0]       tgt_d   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [1:0]        ctr_d   [ENTRIES];

  logic [IDXW-1:0]   idx_l, idx_u;
  logic [TAGW-1:0]   tag_l, tag_u;
  logic              hit_l, hit_u, upd_en;
  logic              unused_bits;

  assign idx_l       = w_pc[IDXW+1:2];
  assign tag_l       = w_pc[31:IDXW+2];
  assign idx_u       = w_upd_pc[IDXW+1:2];
  assign tag_u       = w_upd_pc[31:IDXW+2];
  assign unused_bits = ^{w_pc[1:0], w_upd_pc[1:0], w_upd_tpc[1:0]};

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
    valid_q <= valid_d;
    tag_q   <= tag_d;
    tgt_q   <= tgt_d;
    ctr_q   <= ctr_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + IDXW'(1);
      if (clr_idx_q == IDXW'(ENTRIES - 1)) state_d = S_READY;
    end
  end

  always_comb begin
    w_ready  = (state_q == S_READY);
    hit_l    = w_ready & valid_q[idx_l] & (tag_q[idx_l] == tag_l);
    w_bp_tkn = hit_l & ctr_q[idx_l][1];
    w_ppc    = w_bp_tkn ? {tgt_q[idx_l], 2'b00} : w_pc + 32'd4;
  end

  // Table writes: clear walk owns the array until READY; otherwise train on resolved branches.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    hit_u   = valid_q[idx_u] & (tag_q[idx_u] == tag_u);
    upd_en  = w_upd & w_ready & ~w_rst;
    if (state_q == S_CLEAR) begin
      valid_d[clr_idx_q] = 1'b0;
    end else if (upd_en) begin
      if (hit_u) begin
        if (w_upd_tkn) begin
          tgt_d[idx_u] = w_upd_tpc[31:2];
          if (ctr_q[idx_u] != 2'd3) ctr_d[idx_u] = ctr_q[idx_u] + 2'd1;
        end else if (ctr_q[idx_u] != 2'd0) begin
          ctr_d[idx_u] = ctr_q[idx_u] - 2'd1;
        end
      end else if (w_upd_tkn) begin
        valid_d[idx_u] = 1'b1;
        tag_d[idx_u]   = tag_u;
        tgt_d[idx_u]   = w_upd_tpc[31:2];
        ctr_d[idx_u]   = 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_m_bp_btb.sv
// tb/tb_m_bp_btb.sv - directed vector bench for m_bp_btb
// Inputs change and outputs are sampled on the falling edge; updates take effect at the rising edge.
module tb_m_bp_btb;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic [31:0] w_pc = 32'h0;
  logic        w_bp_tkn;
  logic [31:0] w_ppc;
  logic        w_ready;
  logic        w_upd = 1'b0;
  logic [31:0] w_upd_pc = 32'h0;
  logic        w_upd_tkn = 1'b0;
  logic [31:0] w_upd_tpc = 32'h0;

  int checks = 0;
  int failures = 0;

  m_bp_btb #(.ENTRIES(16)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_pc(w_pc), .w_bp_tkn(w_bp_tkn), .w_ppc(w_ppc),
    .w_ready(w_ready), .w_upd(w_upd), .w_upd_pc(w_upd_pc), .w_upd_tkn(w_upd_tkn),
    .w_upd_tpc(w_upd_tpc)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic        upd;
    logic [31:0] upd_pc;
    logic        upd_tkn;
    logic [31:0] upd_tpc;
    logic [31:0] pc;
    logic        exp_tkn;
    logic [31:0] exp_ppc;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic tkn, input logic [31:0] ppc);
    w_pc = pc;
    #1;
    chk({nm, "_tkn"}, {31'd0, w_bp_tkn}, {31'd0, tkn});
    chk({nm, "_ppc"}, w_ppc, ppc);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tpc);
    w_upd = 1'b1; w_upd_pc = pc; w_upd_tkn = tkn; w_upd_tpc = tpc;
    @(posedge w_clk);
    @(negedge w_clk);
    w_upd = 1'b0;
  endtask

  task automatic clear_window(input string nm, input bit inject);
    for (int i = 0; i < 16; i++) begin
      if (inject && i == 15) begin
        w_upd = 1'b1; w_upd_pc = 32'h8c; w_upd_tkn = 1'b1; w_upd_tpc = 32'h200;
      end
      w_pc = 32'h14;
      #1;
      chk($sformatf("%s_ready%0d", nm, i), {31'd0, w_ready}, 32'd0);
      chk($sformatf("%s_tkn%0d", nm, i), {31'd0, w_bp_tkn}, 32'd0);
      chk($sformatf("%s_ppc%0d", nm, i), w_ppc, 32'h18);
      @(negedge w_clk);
      w_upd = 1'b0;
    end
    #1;
    chk({nm, "_ready_done"}, {31'd0, w_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h14, 1'b1, 32'h0c, 32'h14, 1'b1, 32'h0c};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h18, 1'b0, 32'h1c};
    vecs[2]  = '{1'b1, 32'h14, 1'b0, 32'h0,  32'h14, 1'b0, 32'h18};
    vecs[3]  = '{1'b1, 32'h14, 1'b0, 32'h0,  32'h14, 1'b0, 32'h18};
    vecs[4]  = '{1'b1, 32'h14, 1'b1, 32'h0c, 32'h14, 1'b0, 32'h18};
    vecs[5]  = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h14, 1'b1, 32'h20};
    vecs[6]  = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h14, 1'b1, 32'h20};
    vecs[7]  = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h14, 1'b1, 32'h20};
    vecs[8]  = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h14, 1'b1, 32'h20};
    vecs[9]  = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h14, 1'b1, 32'h20};
    vecs[10] = '{1'b1, 32'h14, 1'b0, 32'h0,  32'h14, 1'b1, 32'h20};
    vecs[11] = '{1'b1, 32'h14, 1'b0, 32'h0,  32'h14, 1'b0, 32'h18};
    vecs[12] = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h14, 1'b1, 32'h20};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h54, 1'b0, 32'h58};
    vecs[14] = '{1'b1, 32'h54, 1'b1, 32'h100, 32'h54, 1'b1, 32'h100};
    vecs[15] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h14, 1'b0, 32'h18};
    vecs[16] = '{1'b1, 32'h40, 1'b0, 32'h80, 32'h40, 1'b0, 32'h44};
    vecs[17] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h56, 1'b1, 32'h100};
    vecs[18] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'hfffffffc, 1'b0, 32'h0};
    vecs[19] = '{1'b1, 32'hfffffffc, 1'b1, 32'h8, 32'hfffffffc, 1'b1, 32'h8};

    @(negedge w_clk);
    w_pc = 32'h14;
    #1;
    chk("rst_ready", {31'd0, w_ready}, 32'd0);
    chk("rst_tkn", {31'd0, w_bp_tkn}, 32'd0);
    chk("rst_ppc", w_ppc, 32'h18);
    @(negedge w_clk);
    w_rst = 1'b0;
    clear_window("clr", 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].upd) upd(vecs[i].upd_pc, vecs[i].upd_tkn, vecs[i].upd_tpc);
      look($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp_tkn, vecs[i].exp_ppc);
    end

    // Same-cycle lookup sees the pre-update (alias-owned, miss) entry.
    w_upd = 1'b1; w_upd_pc = 32'h14; w_upd_tkn = 1'b1; w_upd_tpc = 32'h0c;
    look("haz_same", 32'h14, 1'b0, 32'h18);
    @(posedge w_clk);
    @(negedge w_clk);
    w_upd = 1'b0;
    look("haz_next", 32'h14, 1'b1, 32'h0c);

    // Restart the clear walk mid-sequence at clr_idx=7.
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    repeat (7) @(negedge w_clk);
    #1;
    chk("mid_ready", {31'd0, w_ready}, 32'd0);
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    clear_window("reclr", 1'b1);
    look("post_14", 32'h14, 1'b0, 32'h18);
    look("post_54", 32'h54, 1'b0, 32'h58);
    look("post_top", 32'hfffffffc, 1'b0, 32'h0);
    look("post_8c", 32'h8c, 1'b0, 32'h90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
